// File: rtl/chan_rx_frame_unpacker.sv
// chan_rx_frame_unpacker
// Receive-side frame checker and halfword-to-word packer. It sits behind the
// channel-link receive FIFO, validates each frame's header and length, packs
// payload halfword pairs into 32-bit words and keeps good/bad frame counters
// for programming-interface readback. Malformed frames are drained up to tlast
// so that the following frame starts from a clean header.
module chan_rx_frame_unpacker #(
  parameter logic [3:0] MARKER = 4'hA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:15] s_axis_tdata,
  input  logic [0:1]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [31:0] m_word,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frames_ok_cnt,
  output logic [15:0] frames_bad_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HI    = 2'd1,
    S_LO    = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_HDR   = 2'd0,
    ERR_SHORT = 2'd1,
    ERR_LONG  = 2'd2,
    ERR_KEEP  = 2'd3
  } err_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Registers
  state_t      r_state;
  logic [11:0] r_words_left;
  logic [15:0] r_hi_half;
  logic [31:0] r_m_word;
  logic        r_m_valid;
  logic        r_m_last;
  logic        r_frame_ok;
  logic        r_frame_err;
  err_t        r_err_code;
  logic [15:0] r_frames_ok_cnt;
  logic [15:0] r_frames_bad_cnt;

  // Combinational decode
  logic [15:0] w_data;
  logic [3:0]  w_hdr_marker;
  logic [11:0] w_hdr_len;
  logic        w_keep_ok;
  logic        w_ready;
  logic        w_accept;
  state_t      w_state_nxt;
  logic        w_cnt_load;
  logic        w_hi_load;
  logic        w_word_load;
  logic        w_word_last;
  logic        w_ok;
  logic        w_err;
  err_t        w_err_code;

  // The port is numbered MSB-first; copying it into a descending vector keeps
  // the numeric value, so header field slicing below reads naturally.
  assign w_data       = s_axis_tdata;
  assign w_hdr_marker = w_data[15:12];
  assign w_hdr_len    = w_data[11:0];
  assign w_keep_ok    = (s_axis_tkeep == 2'b11);

  // DRAIN never stalls; otherwise a beat is taken only if the output register
  // is empty or being emptied this cycle. Held low while reset is asserted.
  assign w_ready       = (r_state == S_DRAIN) || !r_m_valid || m_ready;
  assign s_axis_tready = !reset && w_ready;
  assign w_accept      = s_axis_tvalid && s_axis_tready;

  // State register
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would create order races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-beat events (load, emit, good/bad frame)
  // NOTE: every variable gets a default before the case so that no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_hi_load   = 1'b0;
    w_word_load = 1'b0;
    w_word_last = 1'b0;
    w_ok        = 1'b0;
    w_err       = 1'b0;
    w_err_code  = ERR_HDR;
    if (w_accept) begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_keep_ok || (w_hdr_marker != MARKER) || (w_hdr_len == 12'd0)) begin
            w_err       = 1'b1;
            w_err_code  = w_keep_ok ? ERR_HDR : ERR_KEEP;
            w_state_nxt = s_axis_tlast ? S_IDLE : S_DRAIN;
          end else if (s_axis_tlast) begin
            w_err       = 1'b1;
            w_err_code  = ERR_SHORT;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_load  = 1'b1;
            w_state_nxt = S_HI;
          end
        end
        S_HI: begin
          if (!w_keep_ok) begin
            w_err       = 1'b1;
            w_err_code  = ERR_KEEP;
            w_state_nxt = s_axis_tlast ? S_IDLE : S_DRAIN;
          end else if (s_axis_tlast) begin
            // A frame cannot end on the first half of a word.
            w_err       = 1'b1;
            w_err_code  = ERR_SHORT;
            w_state_nxt = S_IDLE;
          end else begin
            w_hi_load   = 1'b1;
            w_state_nxt = S_LO;
          end
        end
        S_LO: begin
          if (!w_keep_ok) begin
            // The half-built word is dropped.
            w_err       = 1'b1;
            w_err_code  = ERR_KEEP;
            w_state_nxt = s_axis_tlast ? S_IDLE : S_DRAIN;
          end else begin
            w_word_load = 1'b1;
            if (r_words_left == 12'd1) begin
              // Header length reached: this is the last word regardless of
              // tlast; a missing tlast means the sender is still talking.
              w_word_last = 1'b1;
              if (s_axis_tlast) begin
                w_ok        = 1'b1;
                w_state_nxt = S_IDLE;
              end else begin
                w_err       = 1'b1;
                w_err_code  = ERR_LONG;
                w_state_nxt = S_DRAIN;
              end
            end else if (s_axis_tlast) begin
              w_err       = 1'b1;
              w_err_code  = ERR_SHORT;
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_HI;
            end
          end
        end
        S_DRAIN: begin
          if (s_axis_tlast) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Payload path: word counter, high-half holding register, output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_words_left <= '0;
      r_hi_half    <= '0;
      r_m_word     <= '0;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
    end else begin
      if (w_cnt_load) begin
        r_words_left <= w_hdr_len;
      end else if (w_word_load) begin
        r_words_left <= r_words_left - 12'd1;
      end
      if (w_hi_load) begin
        r_hi_half <= w_data;
      end
      // A new word may be loaded in the same cycle the old one is taken.
      if (w_word_load) begin
        r_m_word  <= {r_hi_half, w_data};
        r_m_last  <= w_word_last;
        r_m_valid <= 1'b1;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  // Frame status pulses, sticky error code and saturating frame counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_ok       <= 1'b0;
      r_frame_err      <= 1'b0;
      r_err_code       <= ERR_HDR;
      r_frames_ok_cnt  <= '0;
      r_frames_bad_cnt <= '0;
    end else begin
      r_frame_ok  <= w_ok;
      r_frame_err <= w_err;
      if (w_err) begin
        r_err_code <= w_err_code;
      end
      if (w_ok && (r_frames_ok_cnt != CNT_MAX)) begin
        r_frames_ok_cnt <= r_frames_ok_cnt + 16'd1;
      end
      if (w_err && (r_frames_bad_cnt != CNT_MAX)) begin
        r_frames_bad_cnt <= r_frames_bad_cnt + 16'd1;
      end
    end
  end

  assign m_word         = r_m_word;
  assign m_valid        = r_m_valid;
  assign m_last         = r_m_last;
  assign frame_ok       = r_frame_ok;
  assign frame_err      = r_frame_err;
  assign err_code       = r_err_code;
  assign frames_ok_cnt  = r_frames_ok_cnt;
  assign frames_bad_cnt = r_frames_bad_cnt;

endmodule
